vga_term_writer: RTL

//  Write side of the VGA text terminal: consumes a byte stream (CPU/UART) over valid/ready and

---
 rtl/vga_term_defs_pkg.sv | 20 ++
 rtl/vga_term_cursor.sv | 72 +++++++
 rtl/vga_term_writer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_term_defs_pkg.sv
// Shared definitions for the VGA text terminal: control codes, FSM encoding and default geometry.
package vga_term_defs;

    localparam int TERM_W_DEF = 70;
    localparam int TERM_H_DEF = 30;
    localparam logic [7:0] BLANK_DEF = 8'h20;

    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ALL = 2'd1,
        SCROLL  = 2'd2,
        CLR_ROW = 2'd3
    } term_state_t;

endpackage

// File: rtl/vga_term_cursor.sv
// Cursor position tracker: col/row plus a running line_base so no multiplier is needed.
module vga_term_cursor
    import vga_term_defs::*;
#(
    parameter int term_w = TERM_W_DEF,
    parameter int term_h = TERM_H_DEF
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic        inc,
    input  logic        bs,
    input  logic        cr,
    input  logic        newline,
    input  logic        home,
    output logic [11:0] cursor_idx,
    output logic        at_last_col,
    output logic        at_last_row,
    output logic        at_first_col
);

    localparam logic [11:0] W12      = 12'(term_w);
    localparam logic [11:0] LAST_COL = 12'(term_w - 1);
    localparam logic [11:0] LAST_ROW = 12'(term_h - 1);

    logic [11:0] col_reg, col_next;
    logic [11:0] row_reg, row_next;
    logic [11:0] line_base_reg, line_base_next;
    logic [11:0] idx_reg;

    assign at_last_col  = (col_reg == LAST_COL);
    assign at_last_row  = (row_reg == LAST_ROW);
    assign at_first_col = (col_reg == 12'd0);
    assign cursor_idx   = idx_reg;

    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        line_base_next = line_base_reg;
        if (home) begin
            col_next       = 12'd0;
            row_next       = 12'd0;
            line_base_next = 12'd0;
        end else begin
            if (cr)
                col_next = 12'd0;
            else if (inc)
                col_next = col_reg + 12'd1;
            else if (bs && !at_first_col)
                col_next = col_reg - 12'd1;
            // On the last row the caller scrolls instead; the row itself stays put.
            if (newline && !at_last_row) begin
                row_next       = row_reg + 12'd1;
                line_base_next = line_base_reg + W12;
            end
        end
    end

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            col_reg       <= 12'd0;
            row_reg       <= 12'd0;
            line_base_reg <= 12'd0;
            idx_reg       <= 12'd0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            line_base_reg <= line_base_next;
            idx_reg       <= line_base_next + col_next;
        end
    end

endmodule

// File: rtl/vga_term_writer.sv
// Write side of the text terminal: byte stream in, character RAM writes out, with clear and scroll.
module vga_term_writer
    import vga_term_defs::*;
#(
    parameter int          term_w = TERM_W_DEF,
    parameter int          term_h = TERM_H_DEF,
    parameter logic [7:0]  blank  = BLANK_DEF
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] buf_waddr,
    output logic [7:0]  buf_wdata,
    output logic        buf_we,
    output logic [11:0] buf_raddr,
    input  logic [7:0]  buf_rdata,
    output logic [11:0] cursor_idx,
    output logic        busy
);

    localparam logic [11:0] CELLS     = 12'(term_w * term_h);
    localparam logic [11:0] W12       = 12'(term_w);
    localparam logic [11:0] LAST_BASE = 12'(term_w * (term_h - 1));

    term_state_t state_reg, state_next;
    logic [11:0] idx_reg, idx_next;
    logic        we_reg, we_next;
    logic [11:0] waddr_reg, waddr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic [11:0] raddr_reg, raddr_next;
    logic        rd_issue_reg, rd_issue_next;
    logic        rd_valid_reg;
    logic [11:0] rd_dst_reg;
    logic        in_ready_reg, busy_reg;

    logic cur_inc, cur_bs, cur_cr, cur_nl, cur_home;
    logic at_last_col, at_last_row, at_first_col;
    logic scroll_start;

    vga_term_cursor #(
        .term_w (term_w),
        .term_h (term_h)
    ) u_cursor (
        .clk_25M      (clk_25M),
        .rst          (rst),
        .inc          (cur_inc),
        .bs           (cur_bs),
        .cr           (cur_cr),
        .newline      (cur_nl),
        .home         (cur_home),
        .cursor_idx   (cursor_idx),
        .at_last_col  (at_last_col),
        .at_last_row  (at_last_row),
        .at_first_col (at_first_col)
    );

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        we_next       = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        raddr_next    = raddr_reg;
        rd_issue_next = 1'b0;
        cur_inc       = 1'b0;
        cur_bs        = 1'b0;
        cur_cr        = 1'b0;
        cur_nl        = 1'b0;
        cur_home      = 1'b0;
        scroll_start  = 1'b0;

        case (state_reg)
            CLR_ALL: begin
                we_next    = 1'b1;
                waddr_next = idx_reg;
                wdata_next = blank;
                if (idx_reg == CELLS - 12'd1) begin
                    state_next = IDLE;
                    idx_next   = 12'd0;
                    cur_home   = 1'b1;
                end else begin
                    idx_next = idx_reg + 12'd1;
                end
            end

            IDLE: begin
                if (in_valid) begin
                    case (in_data)
                        ASCII_LF: begin
                            cur_cr       = 1'b1;
                            cur_nl       = 1'b1;
                            scroll_start = at_last_row;
                        end
                        ASCII_CR: cur_cr = 1'b1;
                        ASCII_BS: begin
                            if (!at_first_col) begin
                                cur_bs     = 1'b1;
                                we_next    = 1'b1;
                                waddr_next = cursor_idx - 12'd1;
                                wdata_next = blank;
                            end
                        end
                        ASCII_FF: begin
                            state_next = CLR_ALL;
                            idx_next   = 12'd0;
                        end
                        default: begin
                            if (in_data >= 8'h20) begin
                                we_next    = 1'b1;
                                waddr_next = cursor_idx;
                                wdata_next = in_data;
                                if (at_last_col) begin
                                    cur_cr       = 1'b1;
                                    cur_nl       = 1'b1;
                                    scroll_start = at_last_row;
                                end else begin
                                    cur_inc = 1'b1;
                                end
                            end
                        end
                    endcase
                    if (scroll_start) begin
                        state_next    = SCROLL;
                        raddr_next    = W12;
                        rd_issue_next = 1'b1;
                        idx_next      = W12 + 12'd1;
                    end
                end
            end

            SCROLL: begin
                // Read data for the address issued two edges ago is on buf_rdata now.
                if (rd_valid_reg) begin
                    we_next    = 1'b1;
                    waddr_next = rd_dst_reg;
                    wdata_next = buf_rdata;
                end
                if (idx_reg != CELLS) begin
                    raddr_next    = idx_reg;
                    rd_issue_next = 1'b1;
                    idx_next      = idx_reg + 12'd1;
                end else if (!rd_issue_reg) begin
                    state_next = CLR_ROW;
                    idx_next   = LAST_BASE;
                end
            end

            CLR_ROW: begin
                we_next    = 1'b1;
                waddr_next = idx_reg;
                wdata_next = blank;
                if (idx_reg == CELLS - 12'd1) begin
                    state_next = IDLE;
                    idx_next   = 12'd0;
                end else begin
                    idx_next = idx_reg + 12'd1;
                end
            end

            default: begin
                state_next = CLR_ALL;
                idx_next   = 12'd0;
            end
        endcase
    end

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            state_reg    <= CLR_ALL;
            idx_reg      <= 12'd0;
            we_reg       <= 1'b0;
            waddr_reg    <= 12'd0;
            wdata_reg    <= blank;
            raddr_reg    <= 12'd0;
            rd_issue_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_dst_reg   <= 12'd0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            raddr_reg    <= raddr_next;
            rd_issue_reg <= rd_issue_next;
            rd_valid_reg <= rd_issue_reg;
            rd_dst_reg   <= raddr_reg - W12;
            in_ready_reg <= (state_next == IDLE);
            busy_reg     <= (state_next != IDLE);
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign buf_we    = we_reg;
    assign buf_waddr = waddr_reg;
    assign buf_wdata = wdata_reg;
    assign buf_raddr = raddr_reg;

endmodule
